seq_signed_mac: RTL

- Parametrised, sequential successor to the convolution datapath's combinational 8x8 signed multiplier.
- Multiplies two signed two's-complement operands with an iterative shift-add over magnitudes, then applies the sign.
- Optionally adds the product into an internal accumulator, for convolution window sums.
- Valid/ready handshakes on both sides, so it can sit between a window buffer and the result FIFO.

---
 rtl/seq_signed_mac_if.sv | 26 ++
 rtl/seq_signed_mac.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seq_signed_mac_if.sv
// Operand and result handshake bundle for seq_signed_mac.
// The master drives operands and out_ready; the slave (the MAC) drives ready and results.
interface seq_signed_mac_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_a;
  logic [DATA_W-1:0]     in_b;
  logic                  in_acc;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_prod;
  logic [ACC_W-1:0]      out_acc;

  modport master (
    output in_valid, in_a, in_b, in_acc, out_ready,
    input  in_ready, out_valid, out_prod, out_acc
  );

  modport slave (
    input  in_valid, in_a, in_b, in_acc, out_ready,
    output in_ready, out_valid, out_prod, out_acc
  );
endinterface

// File: rtl/seq_signed_mac.sv
// Sequential signed multiply-accumulate: radix-2 shift-add over operand magnitudes,
// sign applied at the end, optional accumulation into a wrapping ACC_W register.
module seq_signed_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_signed_mac_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ZERO,
    S_FIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [PROD_W-1:0]   r_mag_a;     // |a|, shifted left once per CALC edge
  logic [DATA_W-1:0]   r_mag_b;     // |b|, consumed LSB-first
  logic [PROD_W-1:0]   r_mag_p;
  logic                r_sign;
  logic                r_acc_mode;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [PROD_W-1:0]   r_out_prod;
  logic                r_out_valid;
  logic                r_in_ready;

  logic                w_accept;
  logic                w_zero_op;
  logic [PROD_W-1:0]   w_prod;
  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W-1:0]    w_acc_base;

  // Magnitude kept at DATA_W bits unsigned so the most negative operand maps exactly.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

  assign w_accept   = bus.in_valid && r_in_ready;
  assign w_zero_op  = (bus.in_a == '0) || (bus.in_b == '0);
  // A zero magnitude negates to zero, so no negative zero can appear.
  assign w_prod     = r_sign ? (~r_mag_p + 1'b1) : r_mag_p;
  assign w_prod_ext = ACC_W'($signed(w_prod));
  assign w_acc_base = r_acc_mode ? r_acc : '0;

  // NOTE: every register, the accumulator included, sits on the async reset so an
  // aborted operation leaves no stale state; sequential state uses <= only, so all
  // reads in this block see pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mag_a     <= '0;
      r_mag_b     <= '0;
      r_mag_p     <= '0;
      r_sign      <= 1'b0;
      r_acc_mode  <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_prod  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mag_a    <= PROD_W'(abs_val(bus.in_a));
            r_mag_b    <= abs_val(bus.in_b);
            r_mag_p    <= '0;
            r_sign     <= bus.in_a[DATA_W-1] ^ bus.in_b[DATA_W-1];
            r_acc_mode <= bus.in_acc;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= w_zero_op ? S_ZERO : S_CALC;
          end
        end

        S_CALC: begin
          if (r_mag_b[0]) begin
            r_mag_p <= r_mag_p + r_mag_a;
          end
          r_mag_a <= r_mag_a << 1;
          r_mag_b <= r_mag_b >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state <= S_FIN;
          end
        end

        S_ZERO: begin
          r_mag_p <= '0;
          r_state <= S_FIN;
        end

        S_FIN: begin
          r_out_prod  <= w_prod;
          r_acc       <= w_acc_base + w_prod_ext;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end

        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // The accumulator only changes at FIN, so it doubles as the registered out_acc.
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_prod  = r_out_prod;
  assign bus.out_acc   = r_acc;

endmodule
